sevseg_capture: RTL and testbench

Decoder for the multiplexed seven-segment bus driven by the display driver. It samples the active-low anode/cathode lines and filters out ghosting at digit changeover. Each stable pattern is decoded back to its 4-bit value for the selected digit position. It sits beside the display path as a loopback checker and self-test source, and reports per-digit values, validity, frame completion, and decode errors.

---
 rtl/sevseg_capture.sv | 184 ++++++++++++++++++
 tb/tb_sevseg_capture.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_capture.sv
// Loopback decoder for the multiplexed active-low seven-segment bus: filters ghosting, decodes digits, tracks frames.
// Optional err_count output and counter enabled by defining SEVSEG_CAPTURE_ERRCNT_EN.
module sevseg_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FRAME_TIMEOUT = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] anode_in,
  input  logic [6:0] cathode_in,
  output logic [3:0] digit_0,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       stale,
  output logic       pattern_err
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int unsigned NDIG  = 4;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned SMP_W = AN_W + SEG_W;
  localparam int unsigned VAL_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMO_W = 24;

  localparam logic [SMP_W-1:0] SMP_IDLE = '1;
  localparam logic [CNT_W-1:0] CNT_ACC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FRAME_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(FRAME_TIMEOUT);

  // Returns {hit, value}; hit is 0 for any pattern outside the hex font.
  function automatic logic [VAL_W:0] seg_decode(input logic [SEG_W-1:0] seg);
    logic [VAL_W:0] res;
    res = '0;
    case (seg)
      7'b1000000: res = {1'b1, 4'h0};
      7'b1111001: res = {1'b1, 4'h1};
      7'b0100100: res = {1'b1, 4'h2};
      7'b0110000: res = {1'b1, 4'h3};
      7'b0011001: res = {1'b1, 4'h4};
      7'b0010010: res = {1'b1, 4'h5};
      7'b0000010: res = {1'b1, 4'h6};
      7'b1111000: res = {1'b1, 4'h7};
      7'b0000000: res = {1'b1, 4'h8};
      7'b0011000: res = {1'b1, 4'h9};
      7'b0001000: res = {1'b1, 4'hA};
      7'b0000011: res = {1'b1, 4'hB};
      7'b1000110: res = {1'b1, 4'hC};
      7'b0100001: res = {1'b1, 4'hD};
      7'b0000110: res = {1'b1, 4'hE};
      7'b0001110: res = {1'b1, 4'hF};
      default:    res = '0;
    endcase
    return res;
  endfunction

  logic [SMP_W-1:0] w_in;
  logic [SMP_W-1:0] r_smp;
  logic [SMP_W-1:0] r_acc_pat;
  logic [CNT_W-1:0] r_cnt;
  logic             r_accepted;
  logic             r_acc_vld;
  logic [VAL_W-1:0] r_digit [NDIG];
  logic [NDIG-1:0]  r_valid;
  logic [NDIG-1:0]  r_seen;
  logic [TMO_W-1:0] r_tmo;
  logic             r_frame_done;
  logic             r_stale;
  logic             r_perr;

  logic             w_same;
  logic             w_onehot;
  logic             w_acc;
  logic [VAL_W:0]   w_dec;
  logic [NDIG-1:0]  w_pos_mask;
  logic             w_hit;
  logic             w_miss;
  logic             w_frame;
  logic             w_expire;
  logic [NDIG-1:0]  w_valid_nxt;
  logic [NDIG-1:0]  w_seen_nxt;

  assign w_in     = {anode_in, cathode_in};
  assign w_same   = (w_in == r_smp);
  assign w_onehot = $onehot(~r_smp[SMP_W-1:SEG_W]);
  assign w_acc    = w_onehot && (r_cnt == CNT_ACC) && !r_accepted;

  // Second stage decodes the pattern captured on the accepting cycle.
  assign w_dec      = seg_decode(r_acc_pat[SEG_W-1:0]);
  assign w_pos_mask = ~r_acc_pat[SMP_W-1:SEG_W];
  assign w_hit      = r_acc_vld && w_dec[VAL_W];
  assign w_miss     = r_acc_vld && !w_dec[VAL_W];
  assign w_frame    = (r_seen == 4'hF);
  assign w_expire   = !w_frame && (r_tmo == TMO_LAST);

  // Expiry wipes validity first; a decode on the same cycle then re-asserts its own bit.
  always_comb begin
    w_valid_nxt = w_expire ? '0 : r_valid;
    w_seen_nxt  = w_frame ? '0 : r_seen;
    if (w_hit) begin
      w_valid_nxt = w_valid_nxt | w_pos_mask;
      w_seen_nxt  = w_seen_nxt | w_pos_mask;
    end
    if (w_miss) begin
      w_valid_nxt = w_valid_nxt & ~w_pos_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_smp        <= SMP_IDLE;
      r_cnt        <= '0;
      r_accepted   <= 1'b0;
      r_acc_vld    <= 1'b0;
      r_acc_pat    <= SMP_IDLE;
      r_valid      <= '0;
      r_seen       <= '0;
      r_tmo        <= '0;
      r_frame_done <= 1'b0;
      r_stale      <= 1'b0;
      r_perr       <= 1'b0;
      for (int i = 0; i < int'(NDIG); i++) r_digit[i] <= '0;
    end else begin
      r_smp <= w_in;
      if (w_same) begin
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        r_accepted <= r_accepted | w_acc;
      end else begin
        r_cnt      <= '0;
        r_accepted <= 1'b0;
      end
      r_acc_vld    <= w_acc;
      r_acc_pat    <= r_smp;
      r_valid      <= w_valid_nxt;
      r_seen       <= w_seen_nxt;
      r_frame_done <= w_frame;
      r_perr       <= w_miss;
      // A completing frame beats a same-cycle timeout.
      if (w_frame) begin
        r_tmo   <= '0;
        r_stale <= 1'b0;
      end else if (r_tmo != TMO_MAX) begin
        r_tmo <= r_tmo + TMO_W'(1);
        if (w_expire) r_stale <= 1'b1;
      end
      for (int i = 0; i < int'(NDIG); i++) begin
        if (w_hit && w_pos_mask[i]) r_digit[i] <= w_dec[VAL_W-1:0];
      end
    end
  end

  assign digit_0     = r_digit[0];
  assign digit_1     = r_digit[1];
  assign digit_2     = r_digit[2];
  assign digit_3     = r_digit[3];
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign stale       = r_stale;
  assign pattern_err = r_perr;

`ifdef SEVSEG_CAPTURE_ERRCNT_EN
  localparam int unsigned ERR_W = 8;
  logic [ERR_W-1:0] r_err_cnt;

  // Saturating count of undecodable accepted patterns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_miss && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_sevseg_capture.sv
// Bench for sevseg_capture: directed scenarios plus random dwells against a sample-stream reference model.
`timescale 1ns/1ps
module tb_sevseg_capture;

  localparam int S  = 4;
  localparam int FT = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] anode_in;
  logic [6:0] cathode_in;
  logic [3:0] digit_0, digit_1, digit_2, digit_3, digit_valid;
  logic       frame_done, stale, pattern_err;
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
  logic [7:0] err_count;
`endif

  sevseg_capture #(.STABLE_CYCLES(S), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .rst_n(rst_n), .anode_in(anode_in), .cathode_in(cathode_in),
    .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .digit_valid(digit_valid), .frame_done(frame_done), .stale(stale),
    .pattern_err(pattern_err)
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;
  int fd_cnt = 0;
  int perr_cnt = 0;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0011000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic int val_of(input logic [6:0] c);
    for (int v = 0; v < 16; v++) if (seg_of(v) == c) return v;
    return -1;
  endfunction

  function automatic int pos_of(input logic [3:0] an);
    int n = 0;
    int p = -1;
    for (int i = 0; i < 4; i++) if (!an[i]) begin n++; p = i; end
    return (n == 1) ? p : -1;
  endfunction

  // Reference model: tracks runs of identical samples and schedules decodes by absolute cycle.
  typedef struct { int due; logic [10:0] pat; } ev_t;
  ev_t         m_q[$];
  int          m_cyc = 0;
  logic [10:0] m_run = 11'h7FF;
  logic [10:0] m_s;
  int          m_len = 1;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_val = '0;
  logic [3:0]  m_seen = '0;
  logic        m_fd = 1'b0, m_stale = 1'b0, m_perr = 1'b0;
  int          m_tmo = 0;
  int          m_errc = 0;

  task automatic apply_event(input logic [10:0] pat);
    int p, v;
    p = pos_of(pat[10:7]);
    v = val_of(pat[6:0]);
    if (v >= 0) begin
      m_dig[p] = 4'(v);
      m_val[p] = 1'b1;
      m_seen[p] = 1'b1;
    end else begin
      m_perr = 1'b1;
      m_val[p] = 1'b0;
      if (m_errc < 255) m_errc++;
    end
  endtask

  always @(posedge clk) begin : model
    m_cyc++;
    if (!rst_n) begin
      m_run = 11'h7FF; m_len = 1; m_q.delete();
      foreach (m_dig[i]) m_dig[i] = '0;
      m_val = '0; m_seen = '0; m_fd = 1'b0; m_stale = 1'b0; m_perr = 1'b0;
      m_tmo = 0; m_errc = 0;
    end else begin
      m_s = {anode_in, cathode_in};
      if (m_s == m_run) m_len++;
      else begin m_run = m_s; m_len = 1; end
      m_perr = 1'b0;
      if (m_seen == 4'hF) begin
        m_fd = 1'b1; m_seen = '0; m_tmo = 0; m_stale = 1'b0;
      end else begin
        m_fd = 1'b0;
        if (m_tmo < FT) begin
          m_tmo++;
          if (m_tmo == FT) begin m_stale = 1'b1; m_val = '0; end
        end
      end
      while (m_q.size() > 0 && m_q[0].due == m_cyc) begin
        apply_event(m_q[0].pat);
        void'(m_q.pop_front());
      end
      if (m_len == S && pos_of(m_s[10:7]) >= 0) m_q.push_back('{due: m_cyc + 2, pat: m_s});
    end
  end

  function automatic logic [30:0] pack_dut();
    logic [7:0] e;
    e = '0;
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
    e = err_count;
`endif
    return {e, digit_3, digit_2, digit_1, digit_0, digit_valid, frame_done, stale, pattern_err};
  endfunction

  function automatic logic [30:0] pack_model();
    logic [7:0] e;
    e = '0;
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
    e = 8'(m_errc);
`endif
    return {e, m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_val, m_fd, m_stale, m_perr};
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      checks++;
      if (pack_dut() !== pack_model()) begin
        errors++;
        $display("FAIL cycle_compare cyc=%0d dut=%h model=%h", m_cyc, pack_dut(), pack_model());
      end
    end
    if (frame_done === 1'b1) fd_cnt++;
    if (pattern_err === 1'b1) perr_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] c, input int n);
    anode_in = a;
    cathode_in = c;
    repeat (n) @(negedge clk);
  endtask

  int fd0, p0;

  initial begin
    rst_n = 1'b0;
    anode_in = 4'hF;
    cathode_in = 7'h7F;
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    chk("reset_outputs", 32'(pack_dut()), 32'd0);
    rst_n = 1'b1;

    // Basic decode and exact latency
    drive(4'b1110, 7'b0100100, 5);
    chk("basic_before_latency", 32'(digit_valid), 32'h0);
    drive(4'b1110, 7'b0100100, 1);
    chk("basic_digit0", 32'(digit_0), 32'h2);
    chk("basic_valid", 32'(digit_valid), 32'h1);
    drive(4'b1110, 7'b0100100, 4);
    chk("basic_no_frame", 32'(fd_cnt), 32'd0);

    // Full frame 1,2,3,4
    fd0 = fd_cnt;
    drive(4'b1110, 7'b1111001, 8);
    drive(4'b1101, 7'b0100100, 8);
    drive(4'b1011, 7'b0110000, 8);
    drive(4'b0111, 7'b0011001, 8);
    chk("frame_digits", 32'({digit_3, digit_2, digit_1, digit_0}), 32'h4321);
    chk("frame_valid", 32'(digit_valid), 32'hF);
    chk("frame_pulses", 32'(fd_cnt - fd0), 32'd1);

    // Timeout: stale exactly FT cycles after frame_done
    drive(4'hF, 7'h7F, 98);
    chk("tmo_not_yet", 32'({stale, digit_valid}), 32'h0F);
    drive(4'hF, 7'h7F, 1);
    chk("tmo_stale", 32'({stale, digit_valid}), 32'h10);

    // Next frame 5,6,7,8 clears stale
    fd0 = fd_cnt;
    drive(4'b1110, 7'b0010010, 8);
    drive(4'b1101, 7'b0000010, 8);
    drive(4'b1011, 7'b1111000, 8);
    drive(4'b0111, 7'b0000000, 8);
    chk("frame2_digits", 32'({digit_3, digit_2, digit_1, digit_0}), 32'h8765);
    chk("frame2_stale_cleared", 32'({stale, digit_valid}), 32'h0F);
    chk("frame2_pulses", 32'(fd_cnt - fd0), 32'd1);

    // Glitch rejection and non-one-hot anodes
    drive(4'b1110, 7'b1111001, 8);
    drive(4'b1101, 7'b0000000, 3);
    drive(4'b1110, 7'b1111001, 8);
    drive(4'b1111, 7'b0000000, 20);
    drive(4'b1100, 7'b0000000, 20);
    chk("glitch_digit1", 32'(digit_1), 32'h6);
    chk("glitch_digit0", 32'(digit_0), 32'h1);
    chk("glitch_valid", 32'(digit_valid), 32'hF);

    // Bad pattern
    p0 = perr_cnt;
    drive(4'b1011, 7'b1111111, 10);
    chk("bad_pulses", 32'(perr_cnt - p0), 32'd1);
    chk("bad_valid", 32'(digit_valid), 32'hB);
    chk("bad_digit2", 32'(digit_2), 32'h7);
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
    chk("bad_err_count", 32'(err_count), 32'd1);
`endif

    // Reset during the third sample of a digit-7 dwell
    drive(4'b1110, 7'b1111000, 2);
    rst_n = 1'b0;
    drive(4'b1110, 7'b1111000, 1);
    chk("midreset_outputs", 32'(pack_dut()), 32'd0);
    rst_n = 1'b1;
    drive(4'b1110, 7'b1111000, 5);
    chk("midreset_before", 32'(digit_0), 32'h0);
    drive(4'b1110, 7'b1111000, 1);
    chk("midreset_digit0", 32'(digit_0), 32'h7);
    drive(4'b1110, 7'b1111000, 4);

    // Random dwells
    for (int i = 0; i < 400; i++) begin
      int r;
      int n;
      logic [3:0] an;
      logic [6:0] ca;
      r = int'($urandom_range(0, 19));
      n = int'($urandom_range(1, 10));
      an = ~(4'b0001 << $urandom_range(0, 3));
      ca = seg_of(int'($urandom_range(0, 15)));
      if (r == 0) begin
        rst_n = 1'b0;
        drive(anode_in, cathode_in, int'($urandom_range(1, 3)));
        rst_n = 1'b1;
      end else if (r <= 12) begin
        drive(an, ca, n);
      end else if (r <= 14) begin
        drive(an, 7'($urandom), n);
      end else if (r <= 16) begin
        drive(4'hF, 7'($urandom), n);
      end else if (r == 17) begin
        drive(4'($urandom), 7'($urandom), n);
      end else if (r == 18) begin
        drive(an, ca, 30);
      end else begin
        drive(4'hF, 7'h7F, 110);
      end
    end
    drive(4'hF, 7'h7F, 5);
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
